// File: rtl/bin2bcd_seq.sv
// Sequential 8-bit binary to 3-digit BCD converter (double dabble, one bit per cycle).
// Define BIN2BCD_BLANK_EN to blank leading zero digits to 4'hF.
module bin2bcd_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] bin_in,
  output logic       busy,
  output logic       done,
  output logic [3:0] bcd_hundreds,
  output logic [3:0] bcd_tens,
  output logic [3:0] bcd_ones
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  localparam logic [3:0] DigitBlank = 4'hF;
`ifdef BIN2BCD_BLANK_EN
  localparam logic [3:0] RstHundreds = DigitBlank;
  localparam logic [3:0] RstTens     = DigitBlank;
`else
  localparam logic [3:0] RstHundreds = 4'h0;
  localparam logic [3:0] RstTens     = 4'h0;
`endif
  localparam logic [3:0] RstOnes     = 4'h0;
  localparam logic [2:0] LastIter    = 3'd7;

  state_e      state_q, state_d;
  logic [7:0]  bin_q, bin_d;
  logic [11:0] scratch_q, scratch_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [3:0]  hundreds_q, hundreds_d;
  logic [3:0]  tens_q, tens_d;
  logic [3:0]  ones_q, ones_d;

  logic        load;
  logic        last_iter;
  logic [11:0] adjusted;

  // Digits of 5..9 get +3 so the following shift carries correctly into the next digit.
  function automatic logic [3:0] dabble(input logic [3:0] digit);
    return (digit >= 4'd5) ? digit + 4'd3 : digit;
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StShift;
      StShift: if (cnt_q == LastIter) state_d = StDone;
      StDone:  state_d = start ? StShift : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state_q)
      StShift: busy = 1'b1;
      StDone:  done = 1'b1;
      default: ;
    endcase
  end

  assign load      = start && ((state_q == StIdle) || (state_q == StDone));
  assign last_iter = (state_q == StShift) && (cnt_q == LastIter);
  assign adjusted  = {dabble(scratch_q[11:8]), dabble(scratch_q[7:4]), dabble(scratch_q[3:0])};

  // Datapath next-state
  always_comb begin
    bin_d     = bin_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    if (load) begin
      bin_d     = bin_in;
      scratch_d = 12'h000;
      cnt_d     = 3'd0;
    end else if (state_q == StShift) begin
      scratch_d = {adjusted[10:0], bin_q[7]};
      bin_d     = {bin_q[6:0], 1'b0};
      cnt_d     = cnt_q + 3'd1;
    end
  end

  // Result registers capture the post-shift scratch value on the final iteration,
  // so the result is visible in the same cycle done rises.
  always_comb begin
    hundreds_d = hundreds_q;
    tens_d     = tens_q;
    ones_d     = ones_q;
    if (last_iter) begin
      hundreds_d = scratch_d[11:8];
      tens_d     = scratch_d[7:4];
      ones_d     = scratch_d[3:0];
`ifdef BIN2BCD_BLANK_EN
      if (scratch_d[11:8] == 4'd0) begin
        hundreds_d = DigitBlank;
        if (scratch_d[7:4] == 4'd0) tens_d = DigitBlank;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q      <= 8'h00;
      scratch_q  <= 12'h000;
      cnt_q      <= 3'd0;
      hundreds_q <= RstHundreds;
      tens_q     <= RstTens;
      ones_q     <= RstOnes;
    end else begin
      bin_q      <= bin_d;
      scratch_q  <= scratch_d;
      cnt_q      <= cnt_d;
      hundreds_q <= hundreds_d;
      tens_q     <= tens_d;
      ones_q     <= ones_d;
    end
  end

  assign bcd_hundreds = hundreds_q;
  assign bcd_tens     = tens_q;
  assign bcd_ones     = ones_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq; expected digits come from decimal arithmetic.
module tb_bin2bcd_seq;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] bin_in;
  logic       busy;
  logic       done;
  logic [3:0] bcd_hundreds;
  logic [3:0] bcd_tens;
  logic [3:0] bcd_ones;

  int total;
  int bad;

  bin2bcd_seq dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .bin_in       (bin_in),
    .busy         (busy),
    .done         (done),
    .bcd_hundreds (bcd_hundreds),
    .bcd_tens     (bcd_tens),
    .bcd_ones     (bcd_ones)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] model(input int v);
    logic [3:0] h, t, o;
    h = 4'(v / 100);
    t = 4'((v / 10) % 10);
    o = 4'(v % 10);
`ifdef BIN2BCD_BLANK_EN
    if (v < 100) h = 4'hF;
    if (v < 10)  t = 4'hF;
`endif
    return {h, t, o};
  endfunction

  function automatic logic [11:0] reset_digits();
`ifdef BIN2BCD_BLANK_EN
    return 12'hFF0;
`else
    return 12'h000;
`endif
  endfunction

  // Runs one conversion; reports digits, cycle index of done (0 = timed out) and busy count.
  task automatic do_conv(input logic [7:0] v, output logic [11:0] got, output int lat,
                         output int busy_cnt);
    @(negedge clk);
    start  = 1'b1;
    bin_in = v;
    @(negedge clk);
    start    = 1'b0;
    bin_in   = 8'($urandom);
    lat      = 0;
    busy_cnt = 0;
    got      = 12'hxxx;
    for (int i = 1; i <= 20; i++) begin
      if (busy) busy_cnt++;
      if (done) begin
        lat = i;
        got = {bcd_hundreds, bcd_tens, bcd_ones};
        break;
      end
      @(negedge clk);
      bin_in = 8'($urandom);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst    = 1'b1;
    start  = 1'b1;
    bin_in = 8'd255;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL reset_flags: busy=%b done=%b, required 0 0", busy, done);
    end
    total++;
    if ({bcd_hundreds, bcd_tens, bcd_ones} !== reset_digits()) begin
      bad++;
      $display("FAIL reset_digits: got %h, required %h",
               {bcd_hundreds, bcd_tens, bcd_ones}, reset_digits());
    end
    rst   = 1'b0;
    start = 1'b0;
  endtask

  task automatic test_directed();
    int vals[5];
    logic [11:0] got;
    int lat, bc;
    vals = '{255, 0, 99, 7, 128};
    foreach (vals[k]) begin
      do_conv(8'(vals[k]), got, lat, bc);
      total++;
      if (got !== model(vals[k])) begin
        bad++;
        $display("FAIL directed_%0d: got %h, required %h", vals[k], got, model(vals[k]));
      end
      total++;
      if (lat != 9 || bc != 8) begin
        bad++;
        $display("FAIL timing_%0d: done at %0d busy %0d, required 9 and 8", vals[k], lat, bc);
      end
      @(negedge clk);
      total++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL done_pulse_%0d: done=%b busy=%b, required 0 0", vals[k], done, busy);
      end
      repeat (3) begin
        bin_in = 8'($urandom);
        @(negedge clk);
      end
      total++;
      if ({bcd_hundreds, bcd_tens, bcd_ones} !== model(vals[k])) begin
        bad++;
        $display("FAIL hold_%0d: got %h, required %h", vals[k],
                 {bcd_hundreds, bcd_tens, bcd_ones}, model(vals[k]));
      end
    end
  endtask

  task automatic test_busy_ignore();
    int pulses;
    logic [11:0] got;
    pulses = 0;
    got    = 12'hxxx;
    @(negedge clk);
    start  = 1'b1;
    bin_in = 8'd128;
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i <= 25; i++) begin
      if (i == 3) begin
        start  = 1'b1;
        bin_in = 8'd5;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        pulses++;
        got = {bcd_hundreds, bcd_tens, bcd_ones};
      end
      @(negedge clk);
    end
    start = 1'b0;
    total++;
    if (pulses != 1 || got !== model(128)) begin
      bad++;
      $display("FAIL busy_ignore: pulses=%0d digits %h, required 1 and %h",
               pulses, got, model(128));
    end
  endtask

  task automatic test_reset_abort();
    int pulses;
    logic [11:0] got;
    int lat, bc;
    pulses = 0;
    @(negedge clk);
    start  = 1'b1;
    bin_in = 8'd200;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 ||
        {bcd_hundreds, bcd_tens, bcd_ones} !== reset_digits()) begin
      bad++;
      $display("FAIL abort_state: busy=%b done=%b digits %h, required 0 0 %h",
               busy, done, {bcd_hundreds, bcd_tens, bcd_ones}, reset_digits());
    end
    for (int i = 0; i < 12; i++) begin
      if (done) pulses++;
      @(negedge clk);
    end
    total++;
    if (pulses != 0) begin
      bad++;
      $display("FAIL abort_no_done: pulses=%0d, required 0", pulses);
    end
    do_conv(8'd42, got, lat, bc);
    total++;
    if (got !== model(42) || lat != 9) begin
      bad++;
      $display("FAIL after_abort: got %h at %0d, required %h at 9", got, lat, model(42));
    end
  endtask

  task automatic test_back_to_back();
    int first, second, seen;
    logic [11:0] r1, r2;
    first  = 0;
    second = 0;
    seen   = 0;
    r1     = 12'hxxx;
    r2     = 12'hxxx;
    @(negedge clk);
    start  = 1'b1;
    bin_in = 8'd150;
    @(negedge clk);
    for (int i = 1; i <= 30 && seen < 2; i++) begin
      if (done) begin
        seen++;
        if (seen == 1) begin
          first  = i;
          r1     = {bcd_hundreds, bcd_tens, bcd_ones};
          bin_in = 8'd37;
        end else begin
          second = i;
          r2     = {bcd_hundreds, bcd_tens, bcd_ones};
          start  = 1'b0;
        end
      end
      @(negedge clk);
    end
    start = 1'b0;
    total++;
    if (r1 !== model(150) || r2 !== model(37)) begin
      bad++;
      $display("FAIL b2b_digits: got %h %h, required %h %h", r1, r2, model(150), model(37));
    end
    total++;
    if (first != 9 || second - first != 9) begin
      bad++;
      $display("FAIL b2b_period: done at %0d and %0d, required 9 and 18", first, second);
    end
    repeat (12) @(negedge clk);
  endtask

  task automatic test_random();
    logic [11:0] got;
    int lat, bc;
    logic [7:0] v;
    for (int k = 0; k < 24; k++) begin
      v = 8'($urandom);
      if (k == 0) v = 8'd9;
      if (k == 1) v = 8'd10;
      if (k == 2) v = 8'd100;
      do_conv(v, got, lat, bc);
      total++;
      if (got !== model(int'(v)) || lat != 9 || bc != 8) begin
        bad++;
        $display("FAIL random_%0d: got %h lat %0d busy %0d, required %h 9 8",
                 v, got, lat, bc, model(int'(v)));
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    rst    = 1'b1;
    start  = 1'b0;
    bin_in = 8'h00;
    test_reset();
    test_directed();
    test_busy_ignore();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
